// File: rtl/arc4_pkg.sv
// arc4_pkg: shared types and constants for the ARC4 key-scheduling stage.
//   ksa_state_t  - key-schedule FSM states
//   S_MEM_DEPTH  - number of entries in the S memory
//   S_ADDR_W     - S-memory address width
//   ITER_CYCLES  - clocks spent on one full (read/read/write/write) iteration
package arc4_pkg;

   localparam int S_MEM_DEPTH = 256;
   localparam int S_ADDR_W    = 8;
   localparam int ITER_CYCLES = 6;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      RD_SI = 3'd1,
      LD_SI = 3'd2,
      RD_SJ = 3'd3,
      LD_SJ = 3'd4,
      WR_SI = 3'd5,
      WR_SJ = 3'd6,
      DONE  = 3'd7
   } ksa_state_t;

endpackage

// File: rtl/arc4_ksa_if.sv
// arc4_ksa_if: start handshake plus single-port S-memory bus of the
// key-scheduling stage.
//   en/rdy  - start request / idle-and-ready
//   key     - secret key, byte 0 in the most significant byte
//   addr    - S-memory address
//   rddata  - S-memory read data (one cycle after addr)
//   wrdata  - S-memory write data
//   wren    - S-memory write enable
// Modports: slave = the key-schedule engine, master = its environment.
interface arc4_ksa_if #(parameter int KEY_BYTES = 3);

   logic                            en;
   logic                            rdy;
   logic [8*KEY_BYTES-1:0]          key;
   logic [arc4_pkg::S_ADDR_W-1:0]   addr;
   logic [7:0]                      rddata;
   logic [7:0]                      wrdata;
   logic                            wren;

   modport master (output en, key, rddata, input rdy, addr, wrdata, wren);
   modport slave  (input en, key, rddata, output rdy, addr, wrdata, wren);

endinterface

// File: rtl/arc4_ksa.sv
// arc4_ksa: ARC4 key schedule over an S memory that already holds the
// identity permutation. For i = 0..255: j += s[i] + key[i mod KEY_BYTES],
// then swap s[i] and s[j]. Every output is registered.
// Ports:
//   clk  - clock
//   rst  - synchronous, active-high reset
//   bus  - arc4_ksa_if.slave (en/rdy handshake, key, S-memory bus)
// Build option: ARC4_KSA_SKIP_SELF_SWAP_EN - when defined, an iteration whose
// new j equals i skips its read of s[j] and both writes (2 cycles, no write).
module arc4_ksa
   import arc4_pkg::*;
#(
   parameter int KEY_BYTES = 3
) (
   input  logic         clk,
   input  logic         rst,
   arc4_ksa_if.slave    bus
);

   localparam int KW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;

   ksa_state_t              state_r, state_s;
   logic [S_ADDR_W-1:0]     i_r, i_s, j_r, j_s, j_sum_s;
   logic [KW-1:0]           k_r, k_s, k_inc_s;
   logic [7:0]              si_r, si_s, sj_r, sj_s;
   logic [8*KEY_BYTES-1:0]  key_r, key_s;
   logic [S_ADDR_W-1:0]     addr_r, addr_s;
   logic [7:0]              wrdata_r, wrdata_s;
   logic                    wren_r, wren_s;
   logic                    rdy_r, rdy_s;
   logic [7:0]              key_bytes_s [KEY_BYTES];
   logic [7:0]              key_byte_s;

   // Split the latched key into bytes, byte 0 taken from the top of the word.
   always_comb begin
      for (int b = 0; b < KEY_BYTES; b++) begin
         key_bytes_s[b] = key_r[8*(KEY_BYTES-1-b) +: 8];
      end
      key_byte_s = key_bytes_s[k_r];
   end

   // Index arithmetic: new j and the wrapping key-byte counter.
   always_comb begin
      j_sum_s = j_r + bus.rddata + key_byte_s;
      if (k_r == KW'(KEY_BYTES - 1)) begin
         k_inc_s = {KW{1'b0}};
      end else begin
         k_inc_s = k_r + KW'(1);
      end
   end

   // Next-state and next-output logic; outputs are computed one cycle ahead
   // so that they are registered yet valid in the state they belong to.
   always_comb begin
      state_s  = state_r;
      i_s      = i_r;
      j_s      = j_r;
      k_s      = k_r;
      si_s     = si_r;
      sj_s     = sj_r;
      key_s    = key_r;
      addr_s   = addr_r;
      wrdata_s = wrdata_r;
      wren_s   = 1'b0;
      rdy_s    = 1'b0;
      case (state_r)
         IDLE, DONE: begin
            if (bus.en) begin
               key_s   = bus.key;
               i_s     = 8'd0;
               j_s     = 8'd0;
               k_s     = {KW{1'b0}};
               addr_s  = 8'd0;
               state_s = RD_SI;
            end else begin
               rdy_s   = 1'b1;
               state_s = IDLE;
            end
         end
         RD_SI: state_s = LD_SI;
         LD_SI: begin
            si_s = bus.rddata;
            j_s  = j_sum_s;
`ifdef ARC4_KSA_SKIP_SELF_SWAP_EN
            if (j_sum_s == i_r) begin
               // Swapping s[i] with itself is a no-op: advance directly.
               i_s = i_r + 8'd1;
               k_s = k_inc_s;
               if (i_r == 8'd255) begin
                  rdy_s   = 1'b1;
                  state_s = DONE;
               end else begin
                  addr_s  = i_r + 8'd1;
                  state_s = RD_SI;
               end
            end else begin
               addr_s  = j_sum_s;
               state_s = RD_SJ;
            end
`else
            addr_s  = j_sum_s;
            state_s = RD_SJ;
`endif
         end
         RD_SJ: state_s = LD_SJ;
         LD_SJ: begin
            // s[j] goes straight to the write-data register for s[i].
            sj_s     = bus.rddata;
            addr_s   = i_r;
            wrdata_s = bus.rddata;
            wren_s   = 1'b1;
            state_s  = WR_SI;
         end
         WR_SI: begin
            addr_s   = j_r;
            wrdata_s = si_r;
            wren_s   = 1'b1;
            state_s  = WR_SJ;
         end
         WR_SJ: begin
            i_s = i_r + 8'd1;
            k_s = k_inc_s;
            if (i_r == 8'd255) begin
               rdy_s   = 1'b1;
               state_s = DONE;
            end else begin
               addr_s  = i_r + 8'd1;
               state_s = RD_SI;
            end
         end
         default: begin
            rdy_s   = 1'b1;
            state_s = IDLE;
         end
      endcase
   end

   // State, datapath and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r  <= IDLE;
         i_r      <= 8'd0;
         j_r      <= 8'd0;
         k_r      <= {KW{1'b0}};
         si_r     <= 8'd0;
         sj_r     <= 8'd0;
         key_r    <= {(8*KEY_BYTES){1'b0}};
         addr_r   <= 8'd0;
         wrdata_r <= 8'd0;
         wren_r   <= 1'b0;
         rdy_r    <= 1'b1;
      end else begin
         state_r  <= state_s;
         i_r      <= i_s;
         j_r      <= j_s;
         k_r      <= k_s;
         si_r     <= si_s;
         sj_r     <= sj_s;
         key_r    <= key_s;
         addr_r   <= addr_s;
         wrdata_r <= wrdata_s;
         wren_r   <= wren_s;
         rdy_r    <= rdy_s;
      end
   end

   assign bus.addr   = addr_r;
   assign bus.wrdata = wrdata_r;
   assign bus.wren   = wren_r;
   assign bus.rdy    = rdy_r;

endmodule
